ahb_decoder_ds: RTL

//  Parametrised AHB-Lite address decoder with built-in default slave. Decodes HADDR

---
 rtl/ahb_decoder_ds.sv | 111 +++++++++++
 1 files changed

// File: rtl/ahb_decoder_ds.sv
// AHB-Lite address decoder with programmable base/mask regions and a built-in
// default slave that answers unmapped active transfers with a two-cycle ERROR.
module ahb_decoder_ds #(
    parameter int unsigned        W    = 32,
    parameter int unsigned        NSLV = 4,
    parameter logic [NSLV*W-1:0]  BASE = {NSLV{{W{1'b0}}}},
    parameter logic [NSLV*W-1:0]  MASK = {NSLV{{8'hFF, {(W-8){1'b0}}}}},
    parameter int unsigned        SELW = $clog2(NSLV + 1)
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [W-1:0]    HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HREADY,
    output logic [NSLV-1:0] HSEL,
    output logic            hsel_nomap,
    output logic [SELW-1:0] mux_sel_out,
    output logic            hreadyout_ds,
    output logic            hresp_ds,
    input  logic            err_clr,
    output logic            err_valid,
    output logic [W-1:0]    err_addr,
    output logic [7:0]      err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } ds_state_t;

    ds_state_t       state_q;
    ds_state_t       state_d;
    logic [SELW-1:0] hit_idx;
    logic            start;

    // Scanning from the top index down lets the lowest matching region win.
    always_comb begin
        HSEL       = '0;
        hit_idx    = SELW'(NSLV);
        hsel_nomap = 1'b1;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((HADDR & MASK[i*W +: W]) == (BASE[i*W +: W] & MASK[i*W +: W])) begin
                HSEL       = '0;
                HSEL[i]    = 1'b1;
                hit_idx    = SELW'(i);
                hsel_nomap = 1'b0;
            end
        end
    end

    assign start = HREADY & hsel_nomap & HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mux_sel_out <= SELW'(NSLV);
        end else if (HREADY) begin
            mux_sel_out <= hit_idx;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hreadyout_ds = 1'b1;
        hresp_ds     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ERR1;
            end
            ERR1: begin
                hreadyout_ds = 1'b0;
                hresp_ds     = 1'b1;
                state_d      = ERR2;
            end
            ERR2: begin
                hresp_ds = 1'b1;
                state_d  = start ? ERR1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new fault in the same cycle as a clear restarts the log at one entry.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= 8'd0;
        end else if (start) begin
            err_valid <= 1'b1;
            err_addr  <= HADDR;
            if (err_clr) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'd255) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_cnt   <= 8'd0;
        end
    end

endmodule
